// File: rtl/bus_arbiter_rr_pkg.sv
// Shared encodings for the 4-master system bus arbiter and its round-robin picker.
// No logic here; bus-level active-low levels and the FSM state type.
package bus_arbiter_rr_pkg;

    localparam int BUS_MASTER_CH = 4;
    localparam int BUS_OWNER_W   = 2;
    localparam int ARB_STATE_W   = 2;

    typedef enum logic [ARB_STATE_W-1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_ABORT = 2'd2
    } arb_state_t;

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    localparam logic [BUS_MASTER_CH-1:0] GRNT_NONE = '1;

endpackage

// File: rtl/bus_arbiter_rr_rr_pick.sv
// Round-robin picker: first unmasked active request after ptr, wrapping, ptr itself last.
// Latency: purely combinational.
// Backpressure: none; vld low when no unmasked request exists.
module rr_pick
    import bus_arbiter_rr_pkg::*;
(
    input  logic [BUS_MASTER_CH-1:0] req,
    input  logic [BUS_MASTER_CH-1:0] mask,
    input  logic [BUS_OWNER_W-1:0]   ptr,
    output logic                     vld,
    output logic [BUS_OWNER_W-1:0]   idx
);

    always_comb begin
        logic [BUS_OWNER_W-1:0] cand;
        vld  = 1'b0;
        idx  = ptr;
        cand = ptr;
        for (int k = 1; k <= BUS_MASTER_CH; k++) begin
            cand = ptr + BUS_OWNER_W'(k);
            if (!vld && req[cand] && !mask[cand]) begin
                vld = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter with stall watchdog that reclaims the bus and raises a sticky irq.
// Latency: request sampled at edge N drives an active-low grant after edge N; all outputs registered.
// Backpressure: owner keeps the bus until it drops req_; a stall of TIMEOUT_CYCLES cycles forces abort.
module bus_arbiter_rr
    import bus_arbiter_rr_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [BUS_MASTER_CH-1:0] m_req_,
    output logic [BUS_MASTER_CH-1:0] m_grnt_,
    input  logic                     s_as_,
    input  logic                     m_rdy_,
    output logic [BUS_OWNER_W-1:0]   bus_owner,
    output logic                     bus_busy,
    output logic                     to_irq,
    output logic [BUS_OWNER_W-1:0]   to_owner,
    input  logic                     to_clr
);

    arb_state_t               state, state_nxt;
    logic [BUS_MASTER_CH-1:0] grnt_nxt;
    logic [BUS_OWNER_W-1:0]   owner_nxt, ptr, ptr_nxt, to_owner_nxt;
    logic [BUS_MASTER_CH-1:0] mask, mask_nxt;
    logic [CNT_W-1:0]         cnt, cnt_nxt;
    logic                     irq_nxt, busy_nxt;
    logic                     pick_vld;
    logic [BUS_OWNER_W-1:0]   pick_idx;
    logic                     stalled;

    rr_pick u_rr_pick (
        .req  (~m_req_),
        .mask (mask),
        .ptr  (ptr),
        .vld  (pick_vld),
        .idx  (pick_idx)
    );

    assign stalled = (s_as_ == ENABLE_) && (m_rdy_ == DISABLE_);

    always_comb begin
        state_nxt    = state;
        grnt_nxt     = m_grnt_;
        owner_nxt    = bus_owner;
        ptr_nxt      = ptr;
        cnt_nxt      = cnt;
        to_owner_nxt = to_owner;
        irq_nxt      = to_irq & ~to_clr;
        // A master's timeout mask lifts as soon as it is seen not requesting.
        mask_nxt     = mask & ~m_req_;

        case (state)
            ARB_GRANT: begin
                if (m_req_[bus_owner] == DISABLE_) begin
                    // Release takes precedence over a coincident timeout.
                    cnt_nxt = '0;
                    if (pick_vld) begin
                        grnt_nxt  = ~(BUS_MASTER_CH'(1) << pick_idx);
                        owner_nxt = pick_idx;
                        ptr_nxt   = pick_idx;
                    end else begin
                        grnt_nxt  = GRNT_NONE;
                        state_nxt = ARB_IDLE;
                    end
                end else if (stalled) begin
                    if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        grnt_nxt            = GRNT_NONE;
                        cnt_nxt             = '0;
                        irq_nxt             = 1'b1;
                        to_owner_nxt        = bus_owner;
                        mask_nxt[bus_owner] = 1'b1;
                        state_nxt           = ARB_ABORT;
                    end else if (!(&cnt)) begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end else begin
                    cnt_nxt = '0;
                end
            end
            default: begin
                // IDLE and the single ABORT cycle both arbitrate with normal latency.
                grnt_nxt  = GRNT_NONE;
                cnt_nxt   = '0;
                state_nxt = ARB_IDLE;
                if (pick_vld) begin
                    grnt_nxt  = ~(BUS_MASTER_CH'(1) << pick_idx);
                    owner_nxt = pick_idx;
                    ptr_nxt   = pick_idx;
                    state_nxt = ARB_GRANT;
                end
            end
        endcase

        busy_nxt = ~&grnt_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ARB_IDLE;
            m_grnt_   <= GRNT_NONE;
            bus_owner <= '0;
            bus_busy  <= 1'b0;
            to_irq    <= 1'b0;
            to_owner  <= '0;
            mask      <= '0;
            cnt       <= '0;
            ptr       <= BUS_OWNER_W'(BUS_MASTER_CH - 1);
        end else begin
            state     <= state_nxt;
            m_grnt_   <= grnt_nxt;
            bus_owner <= owner_nxt;
            bus_busy  <= busy_nxt;
            to_irq    <= irq_nxt;
            to_owner  <= to_owner_nxt;
            mask      <= mask_nxt;
            cnt       <= cnt_nxt;
            ptr       <= ptr_nxt;
        end
    end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Bench for bus_arbiter_rr: directed scenarios plus random traffic, each cycle compared to a behavioural model.
module tb_bus_arbiter_rr;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] m_req_ = 4'hF;
    logic [3:0] m_grnt_;
    logic       s_as_ = 1'b1;
    logic       m_rdy_ = 1'b1;
    logic [1:0] bus_owner;
    logic       bus_busy;
    logic       to_irq;
    logic [1:0] to_owner;
    logic       to_clr = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    bus_arbiter_rr #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .m_req_    (m_req_),
        .m_grnt_   (m_grnt_),
        .s_as_     (s_as_),
        .m_rdy_    (m_rdy_),
        .bus_owner (bus_owner),
        .bus_busy  (bus_busy),
        .to_irq    (to_irq),
        .to_owner  (to_owner),
        .to_clr    (to_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural model: who holds the bus, how long it has been stalled, who is locked out.
    int         md_owner;     // -1 when nobody holds a grant
    int         md_last;      // round-robin reference (last granted master)
    int         md_shown;     // owner index as reported on bus_owner
    int         md_run;       // consecutive stalled cycles of current owner
    logic [3:0] md_mask;
    logic       md_irq;
    int         md_to_owner;

    function automatic int pick(int last);
        for (int k = 1; k <= 4; k++) begin
            int i;
            i = (last + k) % 4;
            if (m_req_[i] == 1'b0 && md_mask[i] == 1'b0) return i;
        end
        return -1;
    endfunction

    task automatic model_step();
        int  p;
        bit  abort;
        if (reset) begin
            md_owner = -1; md_last = 3; md_shown = 0; md_run = 0;
            md_mask = 4'h0; md_irq = 1'b0; md_to_owner = 0;
            return;
        end
        abort = 1'b0;
        p = pick(md_last);
        if (md_owner >= 0) begin
            if (m_req_[md_owner]) begin
                md_owner = p;
                md_run = 0;
            end else if (!s_as_ && m_rdy_) begin
                md_run++;
                if (md_run >= TO) begin
                    abort = 1'b1;
                    md_to_owner = md_owner;
                    md_owner = -1;
                    md_run = 0;
                end
            end else begin
                md_run = 0;
            end
        end else begin
            md_owner = p;
            md_run = 0;
        end
        if (md_owner >= 0) begin
            md_last = md_owner;
            md_shown = md_owner;
        end
        md_mask = md_mask & ~m_req_;
        if (abort) md_mask[md_to_owner] = 1'b1;
        if (abort) md_irq = 1'b1;
        else if (to_clr) md_irq = 1'b0;
    endtask

    task automatic tick();
        logic [3:0] eg;
        @(posedge clk);
        model_step();
        #1;
        eg = (md_owner < 0) ? 4'hF : ~(4'b0001 << md_owner);
        check("grnt",     32'(m_grnt_),   32'(eg));
        check("owner",    32'(bus_owner), 32'(md_shown));
        check("busy",     32'(bus_busy),  32'(md_owner >= 0));
        check("irq",      32'(to_irq),    32'(md_irq));
        check("to_owner", 32'(to_owner),  32'(md_to_owner));
    endtask

    task automatic do_reset();
        m_req_ = 4'hF; s_as_ = 1'b1; m_rdy_ = 1'b1; to_clr = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int rr_exp [5] = '{0, 1, 2, 3, 0};
        int seqs[$];
        int durs[$];
        int prev, cur, hold, phase;

        // Reset state
        reset = 1'b1;
        tick();
        tick();
        check("rst_grnt",  32'(m_grnt_),   32'hF);
        check("rst_owner", 32'(bus_owner), 32'h0);
        check("rst_busy",  32'(bus_busy),  32'h0);
        check("rst_irq",   32'(to_irq),    32'h0);
        reset = 1'b0;

        // First grant and zero-gap handover
        m_req_ = 4'b1010;
        tick();
        check("first_grnt",  32'(m_grnt_),   32'hE);
        check("first_owner", 32'(bus_owner), 32'h0);
        check("first_busy",  32'(bus_busy),  32'h1);
        tick();
        m_req_ = 4'b1011;
        tick();
        check("handover_grnt",  32'(m_grnt_),   32'hB);
        check("handover_owner", 32'(bus_owner), 32'h2);

        // Full round-robin rotation, each owner holding 3 cycles
        do_reset();
        m_req_ = 4'b0000; prev = -1; hold = 0;
        repeat (16) begin
            tick();
            cur = (m_grnt_ == 4'hF) ? -1 : int'(bus_owner);
            if (cur != prev) begin
                if (prev >= 0) durs.push_back(hold);
                seqs.push_back(cur);
                hold = 1;
            end else begin
                hold++;
            end
            m_req_ = 4'b0000;
            if (cur >= 0 && hold == 3) m_req_[cur] = 1'b1;
            prev = cur;
        end
        for (int k = 0; k < 5; k++)
            check("rr_seq", 32'((k < seqs.size()) ? seqs[k] : -1), 32'(rr_exp[k]));
        for (int k = 0; k < 4; k++)
            check("rr_dur", 32'((k < durs.size()) ? durs[k] : -1), 32'd3);

        // Timeout of m1 with m3 pending
        do_reset();
        m_req_ = 4'b1101;
        tick();
        m_req_ = 4'b0101; s_as_ = 1'b0; m_rdy_ = 1'b1;
        repeat (TO - 1) tick();
        check("pre_abort_grnt", 32'(m_grnt_), 32'hD);
        tick();
        check("abort_grnt",  32'(m_grnt_),  32'hF);
        check("abort_irq",   32'(to_irq),   32'h1);
        check("abort_owner", 32'(to_owner), 32'h1);
        s_as_ = 1'b1;
        tick();
        check("post_abort_grnt", 32'(m_grnt_), 32'h7);
        m_req_ = 4'b1101;
        tick();
        tick();
        check("masked_idle", 32'(m_grnt_), 32'hF);
        m_req_ = 4'b1111;
        tick();
        m_req_ = 4'b1101;
        tick();
        check("regrant_m1", 32'(m_grnt_), 32'hD);
        to_clr = 1'b1;
        tick();
        to_clr = 1'b0;
        check("clr_irq", 32'(to_irq), 32'h0);

        // Release on the timeout cycle, then clear coinciding with abort
        do_reset();
        m_req_ = 4'b1101;
        tick();
        m_req_ = 4'b0101; s_as_ = 1'b0; m_rdy_ = 1'b1;
        repeat (TO - 1) tick();
        m_req_ = 4'b0111;
        tick();
        check("race_grnt", 32'(m_grnt_), 32'h7);
        check("race_irq",  32'(to_irq),  32'h0);
        repeat (TO - 1) tick();
        to_clr = 1'b1;
        tick();
        to_clr = 1'b0;
        check("setwins_irq",   32'(to_irq),   32'h1);
        check("setwins_owner", 32'(to_owner), 32'h3);
        s_as_ = 1'b1;

        // Reset mid-grant
        do_reset();
        m_req_ = 4'b1011;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_grnt",  32'(m_grnt_),   32'hF);
        check("midrst_owner", 32'(bus_owner), 32'h0);
        m_req_ = 4'b1010;
        tick();
        check("midrst_next", 32'(m_grnt_), 32'hE);

        // Random traffic against the model
        do_reset();
        phase = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0) phase = $urandom_range(1);
            for (int i = 0; i < 4; i++)
                if ($urandom_range(3) == 0) m_req_[i] = ~m_req_[i];
            if (phase == 1) begin
                s_as_  = ($urandom_range(19) == 0);
                m_rdy_ = ($urandom_range(19) != 0);
            end else begin
                s_as_  = $urandom_range(1) != 0;
                m_rdy_ = $urandom_range(1) != 0;
            end
            to_clr = ($urandom_range(19) == 0);
            reset  = ($urandom_range(499) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
